// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the register-file writeback
//               path: result width, register address width, bank encoding,
//               the FIFO payload struct and the arbiter source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Register-bank select carried with every result.
    localparam logic BANK_INT = 1'b0;
    localparam logic BANK_FP  = 1'b1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  fp;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Which source FIFO won arbitration.
    typedef enum logic [0:0] {
        SRC_EX = 1'b0,
        SRC_LD = 1'b1
    } wb_src_e;

    // x0 is hard-wired to zero, so writes to it are dropped; f0 is a real
    // register and is not affected.
    function automatic logic is_x0(input wb_entry_t e);
        return (e.fp == BANK_INT) && (e.rd == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO holding writeback entries for one
//               result source. Head entry is visible combinationally.
//               Ports: clk, rst_n (async active-low), push/push_entry,
//               pop, head, full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4            // power of two, >= 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_COUNT = (c_PTR_W + 1)'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    wb_entry_t          r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Flags come only from the registered occupancy, so a full FIFO refuses
    // a push even when a pop happens in the same cycle.
    assign full   = (r_count == c_FULL_COUNT);
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Register-file write-side initiator. Buffers completed results
//               from the execute and load paths in one FIFO each, arbitrates
//               round-robin between the FIFO heads, drops integer x0 writes
//               and drives the single register-file write port.
//               Ports: clk, rst_n (async active-low);
//                 ex_valid/ex_ready/ex_rd/ex_fp/ex_data  execute source
//                 ld_valid/ld_ready/ld_rd/ld_fp/ld_data  load source
//                 wb_en/wb_fp/wb_rd/wb_data              write port
//                 wb_count                               writes issued (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = wb_pkg::XLEN,   // must match the package width
    parameter int DEPTH = 4                // entries per source FIFO
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_fp,
    input  logic [XLEN-1:0]       ex_data,

    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic                  ld_fp,
    input  logic [XLEN-1:0]       ld_data,

    output logic                  wb_en,
    output logic                  wb_fp,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [31:0]           wb_count
);

    wb_entry_t w_ex_in;
    wb_entry_t w_ld_in;
    wb_entry_t w_ex_head;
    wb_entry_t w_ld_head;
    logic      w_ex_full;
    logic      w_ex_empty;
    logic      w_ld_full;
    logic      w_ld_empty;
    logic      w_ex_pop;
    logic      w_ld_pop;

    logic      w_grant_valid;
    wb_src_e   w_grant_src;
    wb_entry_t w_grant_entry;
    logic      w_grant_write;

    wb_src_e               r_last_grant;
    logic                  r_wb_en;
    logic                  r_wb_fp;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;
    logic [31:0]           r_wb_count;

    assign w_ex_in  = '{rd: ex_rd, fp: ex_fp, data: ex_data};
    assign w_ld_in  = '{rd: ld_rd, fp: ld_fp, data: ld_data};
    assign ex_ready = ~w_ex_full;
    assign ld_ready = ~w_ld_full;

    wb_fifo #(.DEPTH(DEPTH)) u_ex_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ex_valid & ex_ready),
        .push_entry (w_ex_in),
        .pop        (w_ex_pop),
        .head       (w_ex_head),
        .full       (w_ex_full),
        .empty      (w_ex_empty)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ld_valid & ld_ready),
        .push_entry (w_ld_in),
        .pop        (w_ld_pop),
        .head       (w_ld_head),
        .full       (w_ld_full),
        .empty      (w_ld_empty)
    );

    // Arbiter: a lone non-empty source always wins; with both pending the
    // source that did not win last time goes next.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_src   = SRC_EX;
        if (!w_ex_empty && !w_ld_empty) begin
            w_grant_valid = 1'b1;
            w_grant_src   = (r_last_grant == SRC_EX) ? SRC_LD : SRC_EX;
        end else if (!w_ld_empty) begin
            w_grant_valid = 1'b1;
            w_grant_src   = SRC_LD;
        end else if (!w_ex_empty) begin
            w_grant_valid = 1'b1;
            w_grant_src   = SRC_EX;
        end
    end

    assign w_ex_pop      = w_grant_valid && (w_grant_src == SRC_EX);
    assign w_ld_pop      = w_grant_valid && (w_grant_src == SRC_LD);
    assign w_grant_entry = (w_grant_src == SRC_LD) ? w_ld_head : w_ex_head;
    // An x0 entry still consumes its grant slot but never reaches the port.
    assign w_grant_write = w_grant_valid && !is_x0(w_grant_entry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SRC_EX;
            r_wb_en      <= 1'b0;
            r_wb_fp      <= BANK_INT;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_wb_count   <= '0;
        end else begin
            r_wb_en <= w_grant_write;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_src;
                r_wb_fp      <= w_grant_entry.fp;
                r_wb_rd      <= w_grant_entry.rd;
                r_wb_data    <= w_grant_entry.data;
            end
            if (w_grant_write) begin
                r_wb_count <= r_wb_count + 32'd1;
            end
        end
    end

    assign wb_en    = r_wb_en;
    assign wb_fp    = r_wb_fp;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Self-checking bench for writeback_unit. Execute results are
//               always integer-bank and load results FP-bank, so each write
//               seen on the port is matched against the head of that
//               source's expected queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_rd = '0;
    logic        ex_fp = 1'b0;
    logic [63:0] ex_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic        ld_fp = 1'b0;
    logic [63:0] ld_data = '0;
    logic        wb_en;
    logic        wb_fp;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [31:0] wb_count;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(64), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_rd    (ex_rd),
        .ex_fp    (ex_fp),
        .ex_data  (ex_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_rd    (ld_rd),
        .ld_fp    (ld_fp),
        .ld_data  (ld_data),
        .wb_en    (wb_en),
        .wb_fp    (wb_fp),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_count (wb_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t        ex_q[$];
    exp_t        ld_q[$];
    logic        grant_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_count = '0;
    int          run_len = 0;
    int          run_max = 0;
    int          ex_stalls = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every wb_en cycle must match the oldest pending
    // entry of the source selected by the bank bit.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (wb_en) begin
                grant_log.push_back(wb_fp);
                run_len++;
                if (run_len > run_max) run_max = run_len;
                if (wb_fp) begin
                    check("ld_write_expected", 64'(ld_q.size() != 0), 64'd1);
                    if (ld_q.size() != 0) begin
                        e = ld_q.pop_front();
                        check("ld_rd", 64'(wb_rd), 64'(e.rd));
                        check("ld_data", wb_data, e.data);
                    end
                end else begin
                    check("ex_write_expected", 64'(ex_q.size() != 0), 64'd1);
                    if (ex_q.size() != 0) begin
                        e = ex_q.pop_front();
                        check("ex_rd", 64'(wb_rd), 64'(e.rd));
                        check("ex_data", wb_data, e.data);
                    end
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Drive n_ex integer results and n_ld FP results, each held valid until
    // accepted. ready is registered, so its value at the negedge is the value
    // the following rising edge will see.
    task automatic stream(input int n_ex, input logic [4:0] ex_rd0, input logic [63:0] ex_d0,
                          input int n_ld, input logic [4:0] ld_rd0, input logic [63:0] ld_d0);
        int ei = 0;
        int li = 0;
        int guard = 0;
        while ((ei < n_ex || li < n_ld) && guard < 200) begin
            @(negedge clk);
            guard++;
            ex_valid = (ei < n_ex);
            ex_rd    = ex_rd0 + 5'(ei);
            ex_fp    = BANK_INT;
            ex_data  = ex_d0 + 64'(ei);
            ld_valid = (li < n_ld);
            ld_rd    = ld_rd0 + 5'(li);
            ld_fp    = BANK_FP;
            ld_data  = ld_d0 + 64'(li);
            if (ex_valid && ex_ready) begin
                if (ex_rd != 5'd0) begin
                    ex_q.push_back('{ex_rd, ex_data});
                    exp_count = exp_count + 32'd1;
                end
                ei++;
            end else if (ex_valid) begin
                ex_stalls++;
            end
            if (ld_valid && ld_ready) begin
                ld_q.push_back('{ld_rd, ld_data});
                exp_count = exp_count + 32'd1;
                li++;
            end
        end
        check("stream_accepted", 64'(ei + li), 64'(n_ex + n_ld));
        @(negedge clk);
        ex_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((ex_q.size() != 0 || ld_q.size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        check("drain_ex", 64'(ex_q.size()), 64'd0);
        check("drain_ld", 64'(ld_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [5:0] pat;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_fp", 64'(wb_fp), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wb_count", 64'(wb_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);

        // ---------------- single write, latency ----------------
        stream(1, 5'd5, 64'hDEAD_BEEF_CAFE_BABE, 0, 5'd0, 64'd0);
        check("lat_not_early", 64'(wb_en), 64'd0);
        @(negedge clk);
        check("lat_wb_en", 64'(wb_en), 64'd1);
        check("lat_wb_fp", 64'(wb_fp), 64'd0);
        check("lat_wb_rd", 64'(wb_rd), 64'd5);
        drain();
        check("single_count", 64'(wb_count), 64'(exp_count));

        // ---------------- contention: ld,ex alternation ----------------
        grant_log.delete();
        run_max = 0;
        stream(3, 5'd1, 64'h1000, 3, 5'd10, 64'h4000_0000_0000_0000);
        drain();
        check("cont_grants", 64'(grant_log.size()), 64'd6);
        pat = '0;
        foreach (grant_log[i]) pat = {pat[4:0], grant_log[i]};
        check("cont_order", 64'(pat), 64'(6'b101010));
        check("cont_run", 64'(run_max), 64'd6);
        check("cont_count", 64'(wb_count), 64'(exp_count));

        // ---------------- x0 filter / f0 write ----------------
        stream(1, 5'd0, 64'hBAD, 0, 5'd0, 64'd0);
        drain();
        check("x0_wb_en", 64'(wb_en), 64'd0);
        check("x0_count", 64'(wb_count), 64'(exp_count));
        stream(0, 5'd0, 64'd0, 1, 5'd0, 64'h3FF0_0000_0000_0000);
        drain();
        check("f0_count", 64'(wb_count), 64'(exp_count));

        // ---------------- backpressure ----------------
        ex_stalls = 0;
        stream(10, 5'd16, 64'hA000, 8, 5'd20, 64'hB000);
        drain();
        check("bp_ex_stalled", 64'(ex_stalls > 0), 64'd1);
        check("bp_count", 64'(wb_count), 64'(exp_count));

        // ---------------- reset mid-operation ----------------
        stream(3, 5'd1, 64'hC000, 3, 5'd1, 64'hD000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wb_en", 64'(wb_en), 64'd0);
        check("mid_rst_wb_fp", 64'(wb_fp), 64'd0);
        check("mid_rst_wb_rd", 64'(wb_rd), 64'd0);
        check("mid_rst_wb_data", wb_data, 64'd0);
        check("mid_rst_wb_count", 64'(wb_count), 64'd0);
        ex_q.delete();
        ld_q.delete();
        exp_count = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ex_ready", 64'(ex_ready), 64'd1);
        check("post_rst_ld_ready", 64'(ld_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("post_rst_idle", 64'(wb_en), 64'd0);
        check("post_rst_count", 64'(wb_count), 64'd0);

        // ---------------- counter wrap ----------------
        @(negedge clk);
        force dut.r_wb_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_wb_count;
        exp_count = 32'hFFFF_FFFF;
        stream(1, 5'd7, 64'hE000, 0, 5'd0, 64'd0);
        drain();
        check("wrap_count", 64'(wb_count), 64'(exp_count));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
